// File: rtl/bitcount_pkg.sv
// Shared definitions for the bitcount checker.
// Holds the checker FSM state encoding and the widths of the sampled count
// value and of the statistics counters.
package bitcount_pkg;

    localparam int CNT_W  = 4;
    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        FIRST  = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage : bitcount_pkg

// File: rtl/bitcount_checker_4_if.sv
// Bus between the upstream counter / observer and the bitcount checker.
//   en       : sample strobe (driven by master)
//   cnt_in   : counter value under observation (driven by master)
//   locked   : checker is in LOCKED
//   err      : one-cycle mismatch pulse while locked
//   err_cnt  : saturating count of mismatches seen while locked
//   wrap_cnt : modulo-256 count of correct 15->0 steps seen while locked
//   last_val : most recently sampled cnt_in
interface bitcount_checker_4_if;
    import bitcount_pkg::*;

    logic              en;
    logic [CNT_W-1:0]  cnt_in;
    logic              locked;
    logic              err;
    logic [STAT_W-1:0] err_cnt;
    logic [STAT_W-1:0] wrap_cnt;
    logic [CNT_W-1:0]  last_val;

    modport master (
        output en, cnt_in,
        input  locked, err, err_cnt, wrap_cnt, last_val
    );

    modport slave (
        input  en, cnt_in,
        output locked, err, err_cnt, wrap_cnt, last_val
    );

endinterface : bitcount_checker_4_if

// File: rtl/sat_counter.sv
// Up-counter with an optional saturate mode.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_inc      : increment by one on this edge
//   i_sat_en   : 1 = stick at all-ones, 0 = wrap modulo 2**W
//   o_q        : registered count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_sat_en,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;
    logic         w_at_max;

    assign w_at_max = &r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_inc && !(i_sat_en && w_at_max)) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_q = r_q;

endmodule : sat_counter

// File: rtl/bitcount_checker_4.sv
// Checks that a 4-bit up-counter steps by exactly one (mod 16) on every
// sampled cycle. The checker locks after LOCK_N consecutive correct steps,
// flags and counts mismatches while locked, and falls back to hunting after
// LOSE_N consecutive mismatches. Correct 15->0 steps while locked are counted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bitcount_checker_4_if (en, cnt_in in; locked, err,
//           err_cnt, wrap_cnt, last_val out; all outputs registered)
module bitcount_checker_4 #(
    parameter int LOCK_N = 4,
    parameter int LOSE_N = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bitcount_checker_4_if.slave   bus
);
    import bitcount_pkg::*;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_good, w_good_nxt;
    logic [CNT_W-1:0]  r_bad, w_bad_nxt;
    logic [CNT_W-1:0]  r_last;
    logic              r_locked;
    logic              r_err, w_err_nxt;
    logic              w_err_inc, w_wrap_inc;
    logic [CNT_W-1:0]  w_exp;
    logic              w_match;
    logic [STAT_W-1:0] w_err_cnt, w_wrap_cnt;

    // 4-bit add wraps naturally, so 15 -> 0 is a correct step.
    assign w_exp   = r_last + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_match = (bus.cnt_in == w_exp);

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_err_nxt   = 1'b0;
        w_err_inc   = 1'b0;
        w_wrap_inc  = 1'b0;
        if (bus.en) begin
            case (r_state)
                FIRST: begin
                    // No previous sample to compare against yet.
                    w_state_nxt = HUNT;
                    w_good_nxt  = '0;
                end
                HUNT: begin
                    if (w_match) begin
                        if (r_good + 1'b1 == CNT_W'(LOCK_N)) begin
                            w_state_nxt = LOCKED;
                            w_good_nxt  = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_good_nxt = r_good + 1'b1;
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_bad_nxt  = '0;
                        w_wrap_inc = (r_last == {CNT_W{1'b1}}) && (bus.cnt_in == '0);
                    end else begin
                        w_err_nxt = 1'b1;
                        w_err_inc = 1'b1;
                        if (r_bad + 1'b1 == CNT_W'(LOSE_N)) begin
                            w_state_nxt = HUNT;
                            w_good_nxt  = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_bad_nxt = r_bad + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = FIRST;
                    w_good_nxt  = '0;
                    w_bad_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FIRST;
            r_good   <= '0;
            r_bad    <= '0;
            r_last   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_good   <= w_good_nxt;
            r_bad    <= w_bad_nxt;
            r_locked <= (w_state_nxt == LOCKED);
            r_err    <= w_err_nxt;
            // Always track the latest sample so a jump resynchronises.
            if (bus.en) begin
                r_last <= bus.cnt_in;
            end
        end
    end

    sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_err_inc),
        .i_sat_en (1'b1),
        .o_q      (w_err_cnt)
    );

    sat_counter #(.W(STAT_W)) u_wrap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc    (w_wrap_inc),
        .i_sat_en (1'b0),
        .o_q      (w_wrap_cnt)
    );

    assign bus.locked   = r_locked;
    assign bus.err      = r_err;
    assign bus.err_cnt  = w_err_cnt;
    assign bus.wrap_cnt = w_wrap_cnt;
    assign bus.last_val = r_last;

endmodule : bitcount_checker_4
